// File: rtl/usr_if.sv
// Bus bundle for the universal shift register: control, serial/parallel data in,
// register contents and serial taps out.
interface usr_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             word_valid;

    modport master (
        output en, mode, sin_r, sin_l, pin,
        input  q, sout_r, sout_l, word_valid
    );

    modport slave (
        input  en, mode, sin_r, sin_l, pin,
        output q, sout_r, sout_l, word_valid
    );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register with hold / shift right / shift left / parallel load,
// plus a per-direction bit counter that strobes word_valid when a full serial word lands.
module universal_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    usr_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic             word_valid_q, word_valid_d;

    logic             shifting;
    dir_e             shift_dir;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        q_d          = q_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        word_valid_d = 1'b0;
        shifting     = 1'b0;
        shift_dir    = dir_q;

        if (bus.en) begin
            case (mode)
                MODE_RIGHT: begin
                    q_d       = {bus.sin_r, q_q[WIDTH-1:1]};
                    shifting  = 1'b1;
                    shift_dir = DIR_RIGHT;
                end
                MODE_LEFT: begin
                    q_d       = {q_q[WIDTH-2:0], bus.sin_l};
                    shifting  = 1'b1;
                    shift_dir = DIR_LEFT;
                end
                MODE_LOAD: begin
                    q_d   = bus.pin;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end

        // A direction change restarts the word; this shift is already its first bit.
        if (shifting) begin
            if (shift_dir != dir_q) begin
                dir_d = shift_dir;
                cnt_d = CNT_W'(1);
            end else if (cnt_q == CNT_LAST) begin
                cnt_d        = '0;
                word_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q          <= '0;
            cnt_q        <= '0;
            dir_q        <= DIR_RIGHT;
            word_valid_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign bus.q          = q_q;
    assign bus.sout_r     = q_q[0];
    assign bus.sout_l     = q_q[WIDTH-1];
    assign bus.word_valid = word_valid_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// Directed table-driven bench for universal_shift_register (WIDTH=4), plus a
// hand-written long right-shift run checking back-to-back word strobes.
module tb_universal_shift_register;
    localparam int W = 4;

    logic clk;
    logic rst;

    usr_if #(.WIDTH(W)) bus ();

    universal_shift_register #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic         rst;
        logic         en;
        logic [1:0]   mode;
        logic         sin_r;
        logic         sin_l;
        logic [W-1:0] pin;
        logic [W-1:0] exp_q;
        logic         exp_wv;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    localparam logic [1:0] HOLD = 2'b00, SR = 2'b01, SL = 2'b10, LD = 2'b11;

    task automatic push(input string tag, input logic r, input logic e, input logic [1:0] m,
                        input logic sr, input logic sl, input logic [W-1:0] p,
                        input logic [W-1:0] eq, input logic ewv);
        vec_t v;
        v.tag = tag; v.rst = r; v.en = e; v.mode = m; v.sin_r = sr; v.sin_l = sl;
        v.pin = p; v.exp_q = eq; v.exp_wv = ewv;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one edge's inputs, let the edge happen, then compare state just after it.
    task automatic apply(input int idx, input logic r, input logic e, input logic [1:0] m,
                         input logic sr, input logic sl, input logic [W-1:0] p,
                         input logic [W-1:0] eq, input logic ewv, input string tag);
        logic [W-1:0] exp_q;
        @(negedge clk);
        rst       = r;
        bus.en    = e;
        bus.mode  = m;
        bus.sin_r = sr;
        bus.sin_l = sl;
        bus.pin   = p;
        @(posedge clk);
        #1;
        exp_q = eq;
        n_vec++;
        check({tag, ".q"},          idx, 32'(bus.q),          32'(exp_q));
        check({tag, ".word_valid"}, idx, 32'(bus.word_valid), 32'(ewv));
        check({tag, ".sout_r"},     idx, 32'(bus.sout_r),     32'(exp_q[0]));
        check({tag, ".sout_l"},     idx, 32'(bus.sout_l),     32'(exp_q[W-1]));
    endtask

    initial begin
        logic [W-1:0] mq;
        logic         b;

        rst = 1'b0; bus.en = 1'b0; bus.mode = HOLD;
        bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.pin = '0;

        // Reset with en=1 and a load pending must still clear.
        push("rst",    0, 1, LD, 0, 0, 4'hF, 4'b0000, 0);
        // Right word 1,0,1,1 then a gapless second word of zeros.
        push("sr_a",   1, 1, SR, 1, 0, 4'h0, 4'b1000, 0);
        push("sr_a",   1, 1, SR, 0, 0, 4'h0, 4'b0100, 0);
        push("sr_a",   1, 1, SR, 1, 0, 4'h0, 4'b1010, 0);
        push("sr_a",   1, 1, SR, 1, 0, 4'h0, 4'b1101, 1);
        push("sr_b",   1, 1, SR, 0, 0, 4'h0, 4'b0110, 0);
        push("sr_b",   1, 1, SR, 0, 0, 4'h0, 4'b0011, 0);
        push("sr_b",   1, 1, SR, 0, 0, 4'h0, 4'b0001, 0);
        push("sr_b",   1, 1, SR, 0, 0, 4'h0, 4'b0000, 1);
        // Left word 1,0,1,1 from reset (first left shift is a direction change).
        push("rst",    0, 0, HOLD, 0, 0, 4'h0, 4'b0000, 0);
        push("sl",     1, 1, SL, 0, 1, 4'h0, 4'b0001, 0);
        push("sl",     1, 1, SL, 0, 0, 4'h0, 4'b0010, 0);
        push("sl",     1, 1, SL, 0, 1, 4'h0, 4'b0101, 0);
        push("sl",     1, 1, SL, 0, 1, 4'h0, 4'b1011, 1);
        // Load 0xA and drain right with zeros; sout_r walks 0,1,0,1.
        push("load",   1, 1, LD, 0, 0, 4'hA, 4'b1010, 0);
        push("drain",  1, 1, SR, 0, 0, 4'h0, 4'b0101, 0);
        push("drain",  1, 1, SR, 0, 0, 4'h0, 4'b0010, 0);
        push("drain",  1, 1, SR, 0, 0, 4'h0, 4'b0001, 0);
        push("drain",  1, 1, SR, 0, 0, 4'h0, 4'b0000, 1);
        push("hold",   1, 1, HOLD, 1, 1, 4'hF, 4'b0000, 0);
        push("en0ld",  1, 0, LD, 0, 0, 4'hF, 4'b0000, 0);
        // Direction change: two rights, then four lefts.
        push("rst",    0, 1, SR, 1, 1, 4'h0, 4'b0000, 0);
        push("dir_r",  1, 1, SR, 1, 0, 4'h0, 4'b1000, 0);
        push("dir_r",  1, 1, SR, 1, 0, 4'h0, 4'b1100, 0);
        push("dir_l",  1, 1, SL, 0, 0, 4'h0, 4'b1000, 0);
        push("dir_l",  1, 1, SL, 0, 1, 4'h0, 4'b0001, 0);
        push("dir_l",  1, 1, SL, 0, 0, 4'h0, 4'b0010, 0);
        push("dir_l",  1, 1, SL, 0, 1, 4'h0, 4'b0101, 1);
        // Enable low for three cycles mid-word.
        push("rst",    0, 0, HOLD, 0, 0, 4'h0, 4'b0000, 0);
        push("en_r",   1, 1, SR, 1, 0, 4'h0, 4'b1000, 0);
        push("en_r",   1, 1, SR, 1, 0, 4'h0, 4'b1100, 0);
        push("en0",    1, 0, SR, 1, 0, 4'h0, 4'b1100, 0);
        push("en0",    1, 0, SR, 1, 0, 4'h0, 4'b1100, 0);
        push("en0",    1, 0, SR, 1, 0, 4'h0, 4'b1100, 0);
        push("en_r",   1, 1, SR, 0, 0, 4'h0, 4'b0110, 0);
        push("en_r",   1, 1, SR, 1, 0, 4'h0, 4'b1011, 1);
        // Load mid-word clears the counter: a fresh four shifts are needed.
        push("rst",    0, 0, HOLD, 0, 0, 4'h0, 4'b0000, 0);
        push("ld_mid", 1, 1, SR, 1, 0, 4'h0, 4'b1000, 0);
        push("ld_mid", 1, 1, SR, 1, 0, 4'h0, 4'b1100, 0);
        push("ld_mid", 1, 1, LD, 0, 0, 4'h5, 4'b0101, 0);
        push("ld_mid", 1, 1, SR, 1, 0, 4'h0, 4'b1010, 0);
        push("ld_mid", 1, 1, SR, 1, 0, 4'h0, 4'b1101, 0);
        push("ld_mid", 1, 1, SR, 1, 0, 4'h0, 4'b1110, 0);
        push("ld_mid", 1, 1, SR, 1, 0, 4'h0, 4'b1111, 1);
        // Reset mid-word discards progress.
        push("rst",    0, 0, HOLD, 0, 0, 4'h0, 4'b0000, 0);
        push("rm_a",   1, 1, SR, 1, 0, 4'h0, 4'b1000, 0);
        push("rm_a",   1, 1, SR, 1, 0, 4'h0, 4'b1100, 0);
        push("rm_a",   1, 1, SR, 1, 0, 4'h0, 4'b1110, 0);
        push("rm_rst", 0, 1, SR, 1, 0, 4'h0, 4'b0000, 0);
        push("rm_b",   1, 1, SR, 1, 0, 4'h0, 4'b1000, 0);
        push("rm_b",   1, 1, SR, 1, 0, 4'h0, 4'b1100, 0);
        push("rm_b",   1, 1, SR, 1, 0, 4'h0, 4'b1110, 0);
        push("rm_b",   1, 1, SR, 1, 0, 4'h0, 4'b1111, 1);

        foreach (vecs[i])
            apply(i, vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].sin_r, vecs[i].sin_l,
                  vecs[i].pin, vecs[i].exp_q, vecs[i].exp_wv, vecs[i].tag);

        // Hand-written run: three back-to-back random right words after reset.
        apply(1000, 0, 1, SL, 0, 1, 4'h0, 4'b0000, 0, "run_rst");
        mq = '0;
        for (int k = 0; k < 3 * W; k++) begin
            b  = 1'($urandom_range(0, 1));
            mq = {b, mq[W-1:1]};
            apply(1001 + k, 1, 1, SR, b, ~b, 4'h0, mq, (k % W) == (W - 1), "run");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
